exu_lsu_reg: RTL and testbench
==============================

EXU_LSU_REG -- requirements
Module: exu_lsu_reg

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width of result, pc and store data.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port flush  input  1  discard all held and incoming entries this cycle.
REQ-005 SHALL have port in_valid  input  1  upstream EXU entry valid.
REQ-006 SHALL have port in_ready  output  1  stage can accept an entry; registered.
REQ-007 SHALL have port in_pc  input  XLEN  instruction PC.
REQ-008 SHALL have port in_inst  input  32  instruction word.
REQ-009 SHALL have port in_alu_result  input  XLEN  raw ALU result, upper half not sign-extended for word ops.
REQ-010 SHALL have port in_inst_32  input  1  word (*W) instruction flag.
REQ-011 SHALL have port in_rd_addr  input  5  destination register.
REQ-012 SHALL have port in_rd_wen  input  1  register write enable.
REQ-013 SHALL have port in_mem_ren / in_mem_wen  input  1 each  load / store request.
REQ-014 SHALL have port in_store_data  input  XLEN  store data.
REQ-015 SHALL have port out_valid  output  1  downstream entry valid.
REQ-016 SHALL have port out_ready  input  1  LSU accepts entry.
REQ-017 SHALL have ports out_pc, out_inst, out_result, out_rd_addr, out_rd_wen, out_mem_ren, out_mem_wen, out_store_data  output  widths as inputs  registered copies of the head entry.

Function
REQ-018 SHALL transfer on the input side when in_valid & in_ready, and on the output side when out_valid & out_ready.
REQ-019 SHALL hold two entries: main (drives outputs) and skid.
REQ-020 SHALL present an accepted entry on outputs exactly 1 cycle after acceptance when main is empty or draining.
REQ-021 SHALL load main when main empty or output transfer occurs: from skid if skid valid, else from input if input transfer occurs, else main becomes empty.
REQ-022 SHALL load skid when an input transfer occurs while main is valid and no output transfer occurs.
REQ-023 SHALL drive in_ready = ~skid_valid, registered; at most one extra entry is absorbed after out_ready falls.
REQ-024 SHALL preserve FIFO order; no entry is dropped or duplicated without flush.
REQ-025 SHALL sign-extend at capture when in_inst_32=1: stored result = {32{r[31]}, r[31:0]}; otherwise store r unmodified.
REQ-026 SHALL force stored rd_wen to 0 when in_rd_addr == 0.
REQ-027 SHALL keep out_* data stable while out_valid & ~out_ready.
REQ-028 SHALL on flush clear main and skid valid at the clock edge, discard any same-cycle input transfer, and drive in_ready=1 in the following cycle.
REQ-029 SHALL treat flush together with out_ready as a flush (no further entry presented).
REQ-030 SHALL not gate datapath registers on flush; only valid bits are cleared.

Reset
REQ-031 SHALL on rst clear main_valid and skid_valid; out_valid=0, in_ready=1 the next cycle.
REQ-032 SHALL reset all out_* data registers to 0.
REQ-033 SHALL give rst priority over flush and any transfer, including mid-stall.

Verification
REQ-034 Back-to-back: in_valid=1 for 4 cycles, out_ready=1 -> outputs appear 1 cycle later in order, in_ready stays 1.
REQ-035 Stall: out_ready=0 with main full, one more entry sent -> skid holds it, in_ready=0 next cycle; out_ready=1 -> both drained in order over 2 cycles.
REQ-036 Word sext: in_alu_result=0x00000000_80000000, in_inst_32=1 -> out_result=0xFFFFFFFF_80000000; same with in_inst_32=0 -> unchanged.
REQ-037 x0 write: in_rd_addr=0, in_rd_wen=1 -> out_rd_wen=0.
REQ-038 Flush with both entries full plus in_valid=1 -> out_valid=0 and in_ready=1 next cycle, no entry emerges afterward.
REQ-039 rst asserted during stall with skid full -> out_valid=0, out_result=0, in_ready=1 next cycle.

Source files
------------

// File: rtl/exu_lsu_reg.sv
// EXU->LSU pipeline register: two-entry (main + skid) buffer.
// Word results are sign-extended and x0 writes dropped at capture.
module exu_lsu_reg #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic            in_inst_32,
  input  logic [4:0]      in_rd_addr,
  input  logic            in_rd_wen,
  input  logic            in_mem_ren,
  input  logic            in_mem_wen,
  input  logic [XLEN-1:0] in_store_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd_addr,
  output logic            out_rd_wen,
  output logic            out_mem_ren,
  output logic            out_mem_wen,
  output logic [XLEN-1:0] out_store_data
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [XLEN-1:0] res;
    logic [4:0]      rd;
    logic            rwen;
    logic            ren;
    logic            wen;
    logic [XLEN-1:0] sd;
  } ent_t;

  ent_t main_q, main_d;
  ent_t skid_q, skid_d;
  ent_t cap;
  logic main_v_q, main_v_d;
  logic skid_v_q, skid_v_d;
  logic rdy_q, rdy_d;
  logic in_fire, out_fire;

  assign in_fire  = in_valid & rdy_q;
  assign out_fire = main_v_q & out_ready;

  // Shape the incoming entry: word sign-extension and x0 write suppression
  always_comb begin
    cap      = '0;
    cap.pc   = in_pc;
    cap.inst = in_inst;
    cap.res  = in_inst_32
             ? {{(XLEN-32){in_alu_result[31]}}, in_alu_result[31:0]}
             : in_alu_result;
    cap.rd   = in_rd_addr;
    cap.rwen = in_rd_wen & (in_rd_addr != 5'd0);
    cap.ren  = in_mem_ren;
    cap.wen  = in_mem_wen;
    cap.sd   = in_store_data;
  end

  // Next state: refill main from skid first, then input; overflow to skid
  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (!main_v_q || out_fire) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else if (in_fire) begin
        main_d   = cap;
        main_v_d = 1'b1;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d   = cap;
      skid_v_d = 1'b1;
    end
    // Flush only kills valid bits; data paths run freely
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end
    rdy_d = ~skid_v_d;
  end

  // State registers with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      rdy_q    <= rdy_d;
    end
  end

  assign in_ready       = rdy_q;
  assign out_valid      = main_v_q;
  assign out_pc         = main_q.pc;
  assign out_inst       = main_q.inst;
  assign out_result     = main_q.res;
  assign out_rd_addr    = main_q.rd;
  assign out_rd_wen     = main_q.rwen;
  assign out_mem_ren    = main_q.ren;
  assign out_mem_wen    = main_q.wen;
  assign out_store_data = main_q.sd;

endmodule

// File: tb/tb_exu_lsu_reg.sv
// Directed bench for exu_lsu_reg: vector table plus
// hand-written reset-during-stall sequence.
module tb_exu_lsu_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [63:0] in_pc, in_alu_result, in_store_data;
  logic [31:0] in_inst;
  logic        in_inst_32, in_rd_wen, in_mem_ren, in_mem_wen;
  logic [4:0]  in_rd_addr;
  logic        out_valid, out_ready;
  logic [63:0] out_pc, out_result, out_store_data;
  logic [31:0] out_inst;
  logic [4:0]  out_rd_addr;
  logic        out_rd_wen, out_mem_ren, out_mem_wen;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exu_lsu_reg #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst),
    .in_alu_result(in_alu_result), .in_inst_32(in_inst_32),
    .in_rd_addr(in_rd_addr), .in_rd_wen(in_rd_wen),
    .in_mem_ren(in_mem_ren), .in_mem_wen(in_mem_wen),
    .in_store_data(in_store_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst),
    .out_result(out_result), .out_rd_addr(out_rd_addr),
    .out_rd_wen(out_rd_wen), .out_mem_ren(out_mem_ren),
    .out_mem_wen(out_mem_wen), .out_store_data(out_store_data)
  );

  typedef struct {
    logic        iv;
    logic [63:0] pc;
    logic [63:0] res;
    logic        i32;
    logic [4:0]  rd;
    logic        rwen;
    logic        ordy;
    logic        fl;
    logic        eov;
    logic        eir;
    logic [63:0] epc;
    logic [63:0] eres;
    logic [4:0]  erd;
    logic        erwen;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [63:0] pc);
    return {16'hA5A5, pc[15:0]};
  endfunction

  function automatic logic [63:0] sd_of(input logic [63:0] pc);
    return {pc[31:0], ~pc[31:0]};
  endfunction

  task automatic add(input logic iv, input logic [63:0] pc,
                     input logic [63:0] res, input logic i32,
                     input logic [4:0] rd, input logic rwen,
                     input logic ordy, input logic fl,
                     input logic eov, input logic eir,
                     input logic [63:0] epc, input logic [63:0] eres,
                     input logic [4:0] erd, input logic erwen);
    vec_t v;
    v.iv = iv; v.pc = pc; v.res = res; v.i32 = i32;
    v.rd = rd; v.rwen = rwen; v.ordy = ordy; v.fl = fl;
    v.eov = eov; v.eir = eir; v.epc = epc; v.eres = eres;
    v.erd = erd; v.erwen = erwen;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic iv, input logic [63:0] pc,
                       input logic [63:0] res, input logic i32,
                       input logic [4:0] rd, input logic rwen,
                       input logic ordy, input logic fl);
    in_valid      = iv;
    in_pc         = pc;
    in_inst       = inst_of(pc);
    in_alu_result = res;
    in_inst_32    = i32;
    in_rd_addr    = rd;
    in_rd_wen     = rwen;
    in_mem_ren    = pc[2];
    in_mem_wen    = pc[3];
    in_store_data = sd_of(pc);
    out_ready     = ordy;
    flush         = fl;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 64'h0, 64'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // back-to-back with word sext and x0 cases
    add(1, 64'h100, 64'h11, 0, 5'd1, 1, 1, 0,
        1, 1, 64'h100, 64'h11, 5'd1, 1);
    add(1, 64'h104, 64'h0000_0000_8000_0000, 1, 5'd2, 1, 1, 0,
        1, 1, 64'h104, 64'hFFFF_FFFF_8000_0000, 5'd2, 1);
    add(1, 64'h108, 64'h0000_0000_8000_0000, 0, 5'd3, 1, 1, 0,
        1, 1, 64'h108, 64'h0000_0000_8000_0000, 5'd3, 1);
    add(1, 64'h10c, 64'h33, 0, 5'd0, 1, 1, 0,
        1, 1, 64'h10c, 64'h33, 5'd0, 0);
    add(0, 64'h0, 64'h0, 0, 5'd0, 0, 1, 0,
        0, 1, 64'h0, 64'h0, 5'd0, 0);
    // stall: main then skid fill, refused entry, drain in order
    add(1, 64'h200, 64'h200, 0, 5'd4, 1, 0, 0,
        1, 1, 64'h200, 64'h200, 5'd4, 1);
    add(1, 64'h204, 64'h7fff_ffff, 1, 5'd5, 1, 0, 0,
        1, 0, 64'h200, 64'h200, 5'd4, 1);
    add(1, 64'h208, 64'h208, 0, 5'd6, 1, 0, 0,
        1, 0, 64'h200, 64'h200, 5'd4, 1);
    add(0, 64'h0, 64'h0, 0, 5'd0, 0, 1, 0,
        1, 1, 64'h204, 64'h7fff_ffff, 5'd5, 1);
    add(0, 64'h0, 64'h0, 0, 5'd0, 0, 1, 0,
        0, 1, 64'h0, 64'h0, 5'd0, 0);
    // flush with both entries full and input valid
    add(1, 64'h300, 64'h300, 0, 5'd7, 1, 0, 0,
        1, 1, 64'h300, 64'h300, 5'd7, 1);
    add(1, 64'h304, 64'h304, 0, 5'd8, 1, 0, 0,
        1, 0, 64'h300, 64'h300, 5'd7, 1);
    add(1, 64'h308, 64'h308, 0, 5'd9, 1, 0, 1,
        0, 1, 64'h0, 64'h0, 5'd0, 0);
    add(0, 64'h0, 64'h0, 0, 5'd0, 0, 1, 0,
        0, 1, 64'h0, 64'h0, 5'd0, 0);
    // flush coinciding with out_ready and a new input
    add(1, 64'h400, 64'h400, 0, 5'd10, 1, 0, 0,
        1, 1, 64'h400, 64'h400, 5'd10, 1);
    add(1, 64'h404, 64'h404, 0, 5'd11, 1, 1, 1,
        0, 1, 64'h0, 64'h0, 5'd0, 0);
    add(0, 64'h0, 64'h0, 0, 5'd0, 0, 1, 0,
        0, 1, 64'h0, 64'h0, 5'd0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      @(negedge clk);
      drive(v.iv, v.pc, v.res, v.i32, v.rd, v.rwen, v.ordy, v.fl);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), {63'd0, out_valid},
          {63'd0, v.eov});
      chk($sformatf("v%0d_in_ready", i), {63'd0, in_ready},
          {63'd0, v.eir});
      if (v.eov) begin
        chk($sformatf("v%0d_pc", i), out_pc, v.epc);
        chk($sformatf("v%0d_result", i), out_result, v.eres);
        chk($sformatf("v%0d_rd", i), {59'd0, out_rd_addr},
            {59'd0, v.erd});
        chk($sformatf("v%0d_rd_wen", i), {63'd0, out_rd_wen},
            {63'd0, v.erwen});
        chk($sformatf("v%0d_inst", i), {32'd0, out_inst},
            {32'd0, inst_of(v.epc)});
        chk($sformatf("v%0d_sd", i), out_store_data, sd_of(v.epc));
        chk($sformatf("v%0d_memrw", i),
            {62'd0, out_mem_ren, out_mem_wen},
            {62'd0, v.epc[2], v.epc[3]});
      end
    end

    // reset while stalled with skid full
    @(negedge clk);
    drive(1, 64'h500, 64'h500, 0, 5'd12, 1, 0, 0);
    @(negedge clk);
    drive(1, 64'h504, 64'h504, 0, 5'd13, 1, 0, 0);
    @(posedge clk);
    #1;
    chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
    chk("stall_pc", out_pc, 64'h500);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 64'h508, 64'h508, 0, 5'd14, 1, 1, 1);
    @(posedge clk);
    #1;
    chk("rst_stall_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_stall_result", out_result, 64'd0);
    chk("rst_stall_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 64'h0, 64'h0, 0, 5'd0, 0, 1, 0);
    @(posedge clk);
    #1;
    chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
